execute_stage: RTL and testbench

- EX stage of the RSA-decryption ASIP pipeline, directly downstream of the forwarding hazard unit.
- Consumes forward_RA/forward_RB to select operands: register-file data, ME-stage result or WB-stage data.
- Executes single-cycle ALU ops and an iterative modular multiply (core RSA primitive); stalls upstream while it runs.
- Registers results into the EX/ME pipeline register.

---
 rtl/asip_pkg.sv | 25 ++
 rtl/execute_stage_if.sv | 34 +++
 rtl/execute_stage_mod_mul.sv | 61 ++++++
 rtl/execute_stage.sv | 74 +++++++
 tb/tb_execute_stage.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/asip_pkg.sv
// asip_pkg: shared opcode, forwarding-select and modmul FSM types for the ASIP pipeline
package asip_pkg;
    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLL    = 4'd5,
        OP_SRL    = 4'd6,
        OP_PASSB  = 4'd7,
        OP_SETMOD = 4'd8,
        OP_MODMUL = 4'd9
    } alu_op_t;
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_ME  = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;
    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mm_state_t;
endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: ID/EX operand bundle in, EX/ME pipeline register and stall out
interface execute_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 6,
    parameter int OP_W       = 4
);
    logic                  valid_ex;
    logic [OP_W-1:0]       alu_op_ex;
    logic [DATA_W-1:0]     ra_data_ex;
    logic [DATA_W-1:0]     rb_data_ex;
    logic [DATA_W-1:0]     imm_ex;
    logic                  use_imm_ex;
    logic [REG_ADDR_W-1:0] rf_ex;
    logic                  reg_write_ex;
    logic [1:0]            forward_RA;
    logic [1:0]            forward_RB;
    logic [DATA_W-1:0]     fwd_me_data;
    logic [DATA_W-1:0]     fwd_wb_data;
    logic                  stall_ex;
    logic [DATA_W-1:0]     result_me;
    logic [REG_ADDR_W-1:0] rf_me;
    logic                  reg_write_me;
    logic                  valid_me;
    modport master (
        output valid_ex, alu_op_ex, ra_data_ex, rb_data_ex, imm_ex, use_imm_ex,
               rf_ex, reg_write_ex, forward_RA, forward_RB, fwd_me_data, fwd_wb_data,
        input  stall_ex, result_me, rf_me, reg_write_me, valid_me
    );
    modport slave (
        input  valid_ex, alu_op_ex, ra_data_ex, rb_data_ex, imm_ex, use_imm_ex,
               rf_ex, reg_write_ex, forward_RA, forward_RB, fwd_me_data, fwd_wb_data,
        output stall_ex, result_me, rf_me, reg_write_me, valid_me
    );
endinterface

// File: rtl/execute_stage_mod_mul.sv
// mod_mul_unit: MSB-first interleaved modular multiplier, one operand bit per cycle
module mod_mul_unit
    import asip_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] m,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    localparam int CW = $clog2(DATA_W);
    localparam int PW = DATA_W + 2;
    mm_state_t         state, next;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     p, t, t1, t2, mm;
    logic [DATA_W-1:0] mul_a, mul_b, mul_m;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end
    always_comb begin
        next = state == IDLE ? (start ? MUL : IDLE) :
               state == MUL  ? (cnt == '0 ? DONE : MUL) : IDLE;
    end
    always_comb begin
        busy   = rst_n && (state == MUL || (state == IDLE && start));
        done   = state == DONE;
        result = (done && mul_m != '0) ? p[DATA_W-1:0] : '0;
    end
    // 2P + a < 3M when P, a < M, so two conditional subtracts restore P < M
    always_comb begin
        mm = {2'b00, mul_m};
        t  = (p << 1) + {2'b00, mul_b[cnt] ? mul_a : '0};
        t1 = t >= mm ? t - mm : t;
        t2 = t1 >= mm ? t1 - mm : t1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p     <= '0;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
            mul_m <= '0;
        end else if (state == IDLE && start) begin
            p     <= '0;
            cnt   <= CW'(DATA_W - 1);
            mul_a <= a;
            mul_b <= b;
            mul_m <= m;
        end else if (state == MUL) begin
            p   <= t2;
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: operand forwarding muxes, ALU, modulus register and EX/ME pipeline register
module execute_stage
    import asip_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 6,
    parameter int OP_W       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    execute_stage_if.slave bus
);
    localparam int SHW = $clog2(DATA_W);
    alu_op_t           op;
    logic [DATA_W-1:0] op_a, op_b, fwd_b, alu_res, mod_reg, mm_result;
    logic              mm_start, mm_busy, mm_done;
    assign op = alu_op_t'(bus.alu_op_ex);
    // selector 2'b11 falls through to the register-file operand
    assign op_a  = bus.forward_RA == FWD_ME ? bus.fwd_me_data :
                   bus.forward_RA == FWD_WB ? bus.fwd_wb_data : bus.ra_data_ex;
    assign fwd_b = bus.forward_RB == FWD_ME ? bus.fwd_me_data :
                   bus.forward_RB == FWD_WB ? bus.fwd_wb_data : bus.rb_data_ex;
    assign op_b  = bus.use_imm_ex ? bus.imm_ex : fwd_b;
    assign mm_start = bus.valid_ex && op == OP_MODMUL;
    mod_mul_unit #(.DATA_W(DATA_W)) u_mm (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mm_start),
        .a      (op_a),
        .b      (op_b),
        .m      (mod_reg),
        .busy   (mm_busy),
        .done   (mm_done),
        .result (mm_result)
    );
    assign bus.stall_ex = mm_busy;
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:    alu_res = op_a + op_b;
            OP_SUB:    alu_res = op_a - op_b;
            OP_AND:    alu_res = op_a & op_b;
            OP_OR:     alu_res = op_a | op_b;
            OP_XOR:    alu_res = op_a ^ op_b;
            OP_SLL:    alu_res = op_a << op_b[SHW-1:0];
            OP_SRL:    alu_res = op_a >> op_b[SHW-1:0];
            OP_PASSB:  alu_res = op_b;
            OP_SETMOD: alu_res = op_a;
            OP_MODMUL: alu_res = mm_done ? mm_result : '0;
            default:   alu_res = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n)                                                 mod_reg <= '0;
        else if (!mm_busy && bus.valid_ex && op == OP_SETMOD)       mod_reg <= op_a;
    end
    // a stalled edge inserts a bubble; result and destination keep their last value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.result_me    <= '0;
            bus.rf_me        <= '0;
            bus.reg_write_me <= 1'b0;
            bus.valid_me     <= 1'b0;
        end else if (mm_busy) begin
            bus.reg_write_me <= 1'b0;
            bus.valid_me     <= 1'b0;
        end else begin
            bus.result_me    <= alu_res;
            bus.rf_me        <= bus.rf_ex;
            bus.reg_write_me <= bus.reg_write_ex && op != OP_SETMOD;
            bus.valid_me     <= bus.valid_ex;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_execute_stage;
    import asip_pkg::*;
    typedef struct {
        string       nm;
        logic [31:0] res;
        logic [5:0]  rf;
        logic        rw;
        bit          consec;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] rf_n = 6'd1;
    exp_t       q[$];
    exp_t       e;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         prev_valid = 0;
    bit         prev_stall = 0;
    always #5 clk = ~clk;
    execute_stage_if bus ();
    execute_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) chk("bubble_valid_me", bus.valid_me, 0);
            if (bus.valid_me) begin
                if (q.size() == 0) chk("unexpected_valid_me", bus.valid_me, 0);
                else begin
                    e = q.pop_front();
                    chk({e.nm, "_result"}, bus.result_me, e.res);
                    chk({e.nm, "_rf"}, bus.rf_me, e.rf);
                    chk({e.nm, "_reg_write"}, bus.reg_write_me, e.rw);
                    if (e.consec) chk({e.nm, "_consecutive"}, prev_valid, 1);
                end
            end
        end
        prev_valid = rst_n && bus.valid_me;
        prev_stall = rst_n && bus.stall_ex;
    end
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.valid_ex     = 1'b1;
        bus.alu_op_ex    = op;
        bus.ra_data_ex   = a;
        bus.rb_data_ex   = b;
        bus.imm_ex       = '0;
        bus.use_imm_ex   = 1'b0;
        bus.forward_RA   = 2'b00;
        bus.forward_RB   = 2'b00;
        bus.reg_write_ex = 1'b1;
        bus.rf_ex        = rf_n;
        rf_n++;
    endtask
    task automatic run(input string name, input logic [31:0] r, input logic rw, input bit consec, input int exp_st);
        int st = 0;
        bit s;
        q.push_back('{nm: name, res: r, rf: bus.rf_ex, rw: rw, consec: consec});
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            s = bus.stall_ex;
            st += int'(s);
            @(posedge clk);
            #1;
            if (!s) break;
        end
        chk({name, "_stall_cycles"}, st, exp_st);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.fwd_me_data = 32'd10;
        bus.fwd_wb_data = 32'd20;
        drive(OP_ADD, 32'd3, 32'd4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_result_me", bus.result_me, 0);
        chk("reset_rf_me", bus.rf_me, 0);
        chk("reset_reg_write_me", bus.reg_write_me, 0);
        chk("reset_valid_me", bus.valid_me, 0);
        chk("reset_stall_ex", bus.stall_ex, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run("add_first", 32'd7, 1'b1, 0, 0);
        drive(OP_ADD, 32'd1, 32'd5); bus.forward_RA = 2'b01; run("fwd_me", 32'd15, 1'b1, 1, 0);
        drive(OP_ADD, 32'd1, 32'd5); bus.forward_RA = 2'b10; run("fwd_wb", 32'd25, 1'b1, 1, 0);
        drive(OP_ADD, 32'd1, 32'd5); bus.forward_RA = 2'b11; run("fwd_11", 32'd6, 1'b1, 1, 0);
        drive(OP_ADD, 32'd1, 32'd5); bus.use_imm_ex = 1'b1; bus.imm_ex = 32'd100; bus.forward_RB = 2'b01;
        run("imm", 32'd101, 1'b1, 1, 0);
        drive(OP_SUB, 32'd0, 32'd1);                 run("sub_wrap", 32'hFFFF_FFFF, 1'b1, 1, 0);
        drive(OP_SLL, 32'd1, 32'd33);                run("sll_33", 32'd2, 1'b1, 1, 0);
        drive(OP_SRL, 32'h8000_0000, 32'd31);        run("srl_31", 32'd1, 1'b1, 1, 0);
        drive(OP_AND, 32'h0000_F0F0, 32'h0000_FF00); run("and", 32'h0000_F000, 1'b1, 1, 0);
        drive(OP_OR, 32'h0000_F0F0, 32'h0000_FF00);  run("or", 32'h0000_FFF0, 1'b1, 1, 0);
        drive(OP_XOR, 32'h0000_F0F0, 32'h0000_FF00); run("xor", 32'h0000_0FF0, 1'b1, 1, 0);
        drive(OP_PASSB, 32'd0, 32'h0000_ABCD);       run("passb", 32'h0000_ABCD, 1'b1, 1, 0);
        drive(4'd12, 32'd9, 32'd9);                  run("op12", 32'd0, 1'b1, 1, 0);
        drive(OP_SETMOD, 32'd11, 32'd0);             run("setmod_11", 32'd11, 1'b0, 1, 0);
        drive(OP_MODMUL, 32'd7, 32'd5);              run("modmul_7x5", 32'd2, 1'b1, 0, 33);
        drive(OP_ADD, 32'd2, 32'd2);                 run("add_after_mm", 32'd4, 1'b1, 1, 0);
        drive(OP_SETMOD, 32'hFFFF_FFFB, 32'd0);      run("setmod_big", 32'hFFFF_FFFB, 1'b0, 1, 0);
        drive(OP_MODMUL, 32'hFFFF_FFF6, 32'hFFFF_FFF6); run("modmul_m5sq", 32'd25, 1'b1, 0, 33);
        drive(OP_MODMUL, 32'hFFFF_FFFA, 32'hFFFF_FFFA); run("modmul_m1sq", 32'd1, 1'b1, 0, 33);
        drive(OP_SETMOD, 32'd7, 32'd0);              run("setmod_7", 32'd7, 1'b0, 1, 0);
        drive(OP_MODMUL, 32'd2, 32'd3);              run("b2b_mm1", 32'd6, 1'b1, 0, 33);
        drive(OP_MODMUL, 32'd3, 32'd4);              run("b2b_mm2", 32'd5, 1'b1, 0, 33);
        drive(OP_ADD, 32'd1, 32'd1);                 run("b2b_add", 32'd2, 1'b1, 1, 0);
        drive(OP_MODMUL, 32'd5, 32'd6);
        repeat (11) @(posedge clk);
        #1;
        chk("abort_stall_before_reset", bus.stall_ex, 1);
        rst_n = 1'b0;
        bus.valid_ex = 1'b0;
        @(negedge clk);
        chk("abort_stall_in_reset", bus.stall_ex, 0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_valid_me", bus.valid_me, 0);
        chk("abort_reg_write_me", bus.reg_write_me, 0);
        chk("abort_result_me", bus.result_me, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_stall", bus.stall_ex, 0);
        @(posedge clk);
        #1;
        drive(OP_MODMUL, 32'd3, 32'd4);              run("modmul_m0", 32'd0, 1'b1, 0, 33);
        drive(OP_ADD, 32'd0, 32'd1);                 run("add_last", 32'd1, 1'b1, 1, 0);
        bus.valid_ex = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
